sprite_rom_arbiter: RTL and testbench
=====================================

# sprite_rom_arbiter

Round-robin arbiter that shares the single-port sprite ROM among the game-logic sprite renderers (player, alien grid, bullets, shields). It sits between the per-sprite requesters in game logic and the ROM. It grants at most one read per cycle and returns each read's data tagged with the requester index. It runs on the pixel clock domain, so all requesters and the ROM share `clk`.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `ADDR_W`, default 10: sprite ROM address width.
- `DATA_W`, default 12: ROM word width, RGB444.
- `ROM_LAT`, default 1: ROM read latency in cycles, from `rom_en` to `rom_data` valid, 1..3.
- `clk`  in  1: the single clock, the pixel clock.
- `reset`  in  1: asynchronous, active-low. Asserted when 0.
- `req`  in  N_REQ: per-requester read request, level.
- `req_addr`  in  N_REQ*ADDR_W: packed addresses. Slice i is `[i*ADDR_W +: ADDR_W]`.
- `gnt`  out  N_REQ: one-hot or zero, registered. Marks the accepted request.
- `rom_en`  out  1: ROM read strobe, registered.
- `rom_addr`  out  ADDR_W: ROM address, registered.
- `rom_data`  in  DATA_W: ROM read data.
- `rd_valid`  out  1: `rd_data`/`rd_id` valid this cycle.
- `rd_id`  out  $clog2(N_REQ): index of the requester that owns `rd_data`.
- `rd_data`  out  DATA_W: equals `rom_data`, combinational pass-through.

## Operation
- **Request protocol:** a requester raises `req[i]` with a stable `req_addr` slice and holds both until it sees `gnt[i]`=1.
  - `req[i]` sampled in a cycle where `gnt[i]`=1 is ignored, because that cycle is the requester's acknowledge cycle.
  - A requester can therefore win at most every other cycle.
  - Different requesters can win on back-to-back cycles.
- **Eligibility:** `elig = req & ~gnt`.
- **Arbitration:** round-robin with pointer `ptr` (0..N_REQ-1).
  - The winner is the first eligible index searching `ptr`, `ptr+1`, … with wrap modulo N_REQ.
  - After a grant to index w, `ptr` becomes (w+1) mod N_REQ.
  - With no eligible request, `ptr` holds and `gnt`, `rom_en` go 0.
- **Grant effects** (registered, next edge):
  - `gnt[w]`=1.
  - `rom_en`=1.
  - `rom_addr` = slice w.
  - w is pushed into a ROM_LAT-deep tag pipeline together with a valid bit.
- **Return:** `rd_valid` and `rd_id` are the pipeline output. `rd_data` is `rom_data` unmodified.
- **Reset values:**
  - `gnt`=0, `rom_en`=0, `rom_addr`=0.
  - `rd_valid`=0, `rd_id`=0.
  - `ptr`=0.
  - Tag pipeline cleared.
- **Reset mid-operation:** in-flight reads are discarded and no `rd_valid` is produced for them. Requesters must re-request after reset.
- **Idle:** while `rom_en`=0, `rom_addr` holds its last value.

## Timing
- Request sampled at edge k → `gnt`/`rom_en`/`rom_addr` valid in cycle k+1.
- `rd_valid` with the matching `rd_id` in cycle k+1+ROM_LAT.
- **Throughput:** one ROM read per cycle while at least two requesters are active. With a single requester, one read per two cycles.
- **Fairness:** a continuously requesting requester waits at most N_REQ-1 grants.
- No combinational path from `req` to `gnt`/`rom_*`. The only combinational path is `rom_data` → `rd_data`.

## Configuration
- `SPRITE_ARB_FIXED_PRIO_EN`
  - **Defined:** fixed priority. Lowest eligible index wins. `ptr` is not implemented, so it has no effect and no flops.
  - **Undefined (default):** round-robin as above.
- Handshake, latency and reset behaviour are identical in both modes.

## Structure
- **Package `sprite_arb_pkg`:**
  - `ROM_LAT_MAX` = 3.
  - `N_REQ_MAX` = 8.
  - Typedef `req_id_t` (3-bit) used for `rd_id` and the tag pipeline.
  - Requester index constants: `REQ_PLAYER`=0, `REQ_ALIEN`=1, `REQ_BULLET`=2, `REQ_SHIELD`=3.
- **Sub-module `rr_priority_picker`:**
  - Combinational.
  - Inputs: `elig` and `ptr`. Outputs: one-hot winner, winner index, any-valid.
  - Implemented with a double-width masked priority encoder.
- The tag pipeline stays inline in `sprite_rom_arbiter`.

## Test plan
- **Single request:** `req`=0001, addr 0x155, ROM_LAT=1 → cycle+1 `gnt`=0001, `rom_addr`=0x155; cycle+2 `rd_valid`=1, `rd_id`=0, `rd_data`=`rom_data`; `req` still held in the `gnt` cycle gets no second grant.
- **All requesting:** `req`=1111 held continuously (each requester re-raises after its `gnt`) → grant order 0,1,2,3,0,…; exactly one grant per cycle and no gaps once `ptr` rotates.
- **Round-robin pointer:** `ptr`=2, `req`=0011 → `gnt`=0001, then `ptr`=1.
- **Fixed-priority build:** with `SPRITE_ARB_FIXED_PRIO_EN` defined, same stimulus → requester 0 wins whenever eligible.
- **Reset with reads in flight:** ROM_LAT=3, 3 grants outstanding, assert `reset` low for 1 cycle → all outputs 0 immediately and no `rd_valid` for the dropped reads; the first request after release grants index 0 first.
- **ROM_LAT sweep:** ROM_LAT ∈ {1,2,3}, random `req`/addr with a scoreboard → every grant yields exactly one `rd_valid` exactly ROM_LAT cycles later, with the correct `rd_id` and the data at the granted address.

Source files
------------

// File: rtl/sprite_arb_pkg.sv
// Shared constants and types for the sprite ROM arbiter.
package sprite_arb_pkg;

  localparam int unsigned ROM_LAT_MAX = 3;
  localparam int unsigned N_REQ_MAX   = 8;

  typedef logic [2:0] req_id_t;

  localparam req_id_t REQ_PLAYER = 3'd0;
  localparam req_id_t REQ_ALIEN  = 3'd1;
  localparam req_id_t REQ_BULLET = 3'd2;
  localparam req_id_t REQ_SHIELD = 3'd3;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first eligible index at or after ptr, with wrap.
module rr_priority_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0] dbl;

  always_comb begin
    // Lower copy masked below ptr; upper copy unmasked supplies the wrap-around.
    dbl = {elig, elig};
    for (int unsigned i = 0; i < N; i++) begin
      dbl[i] = elig[i] && (i >= 32'(ptr));
    end
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int unsigned i = 0; i < 2*N; i++) begin
      if (!any && dbl[i]) begin
        any                          = 1'b1;
        idx                          = IDX_W'((i < N) ? i : i - N);
        onehot[(i < N) ? i : i - N]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing the sprite ROM; returns data tagged with requester id.
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed (lowest index wins) priority.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  output logic [N_REQ-1:0]           gnt,
  output logic                       rom_en,
  output logic [ADDR_W-1:0]          rom_addr,
  input  logic [DATA_W-1:0]          rom_data,
  output logic                       rd_valid,
  output logic [$clog2(N_REQ)-1:0]   rd_id,
  output logic [DATA_W-1:0]          rd_data
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]  elig;
  logic [N_REQ-1:0]  win_onehot;
  logic [ID_W-1:0]   win_idx;
  logic              win_any;
  logic [ID_W-1:0]   ptr;
  logic [ADDR_W-1:0] sel_addr;
  req_id_t           gnt_id;
  logic [ROM_LAT-1:0] tag_v;
  req_id_t           tag_id [ROM_LAT];

  // A requester in its acknowledge cycle is not eligible again.
  assign elig = req & ~gnt;

  rr_priority_picker #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_picker (
    .elig   (elig),
    .ptr    (ptr),
    .onehot (win_onehot),
    .idx    (win_idx),
    .any    (win_any)
  );

  always_comb begin
    sel_addr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_onehot[i]) sel_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (win_any) begin
      ptr <= (32'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
    end
  end
`endif

  // Tag pipeline is fed from the registered grant so its output lines up with rom_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt      <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      gnt_id   <= '0;
      tag_v    <= '0;
      for (int unsigned i = 0; i < ROM_LAT; i++) tag_id[i] <= '0;
    end else begin
      gnt    <= win_onehot;
      rom_en <= win_any;
      if (win_any) begin
        rom_addr <= sel_addr;
        gnt_id   <= req_id_t'(win_idx);
      end
      tag_v[0]  <= rom_en;
      tag_id[0] <= gnt_id;
      for (int unsigned i = 1; i < ROM_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign rd_valid = tag_v[ROM_LAT-1];
  assign rd_id    = tag_id[ROM_LAT-1][ID_W-1:0];
  assign rd_data  = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter at ROM_LAT 1, 2 and 3 with behavioural ROMs.
module tb_sprite_rom_arbiter;
  import sprite_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [39:0] req_addr;

  logic [3:0]  gnt1, gnt2, gnt3;
  logic        en1, en2, en3;
  logic [9:0]  addr1, addr2, addr3;
  logic [11:0] data1, data2, data3;
  logic        v1, v2, v3;
  logic [1:0]  id1, id2, id3;
  logic [11:0] rd1, rd2, rd3;

  logic [11:0] r1;
  logic [11:0] r2 [2];
  logic [11:0] r3 [3];

  // reference arbiter model and grant history (index = cycles since rom_en)
  logic [3:0]  m_gnt;
  logic        m_en;
  logic [9:0]  m_addr;
  int          m_ptr;
  logic        hv [4];
  int          hid [4];
  logic [9:0]  ha [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [11:0] romf(input logic [9:0] a);
    return {a[1:0], a} ^ 12'h5A3;
  endfunction

  always @(posedge clk) begin
    r1    <= romf(addr1);
    r2[0] <= romf(addr2);
    r2[1] <= r2[0];
    r3[0] <= romf(addr3);
    r3[1] <= r3[0];
    r3[2] <= r3[1];
  end
  assign data1 = r1;
  assign data2 = r2[1];
  assign data3 = r3[2];

  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(10), .DATA_W(12), .ROM_LAT(1)) u1 (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt1), .rom_en(en1),
    .rom_addr(addr1), .rom_data(data1), .rd_valid(v1), .rd_id(id1), .rd_data(rd1));
  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(10), .DATA_W(12), .ROM_LAT(2)) u2 (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt2), .rom_en(en2),
    .rom_addr(addr2), .rom_data(data2), .rd_valid(v2), .rd_id(id2), .rd_data(rd2));
  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(10), .DATA_W(12), .ROM_LAT(3)) u3 (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .gnt(gnt3), .rom_en(en3),
    .rom_addr(addr3), .rom_data(data3), .rd_valid(v3), .rd_id(id3), .rd_data(rd3));

  task automatic model_clear();
    m_gnt = '0; m_en = 1'b0; m_addr = '0; m_ptr = 0;
    for (int j = 0; j < 4; j++) begin hv[j] = 1'b0; hid[j] = 0; ha[j] = '0; end
  endtask

  // Drive one cycle of stimulus (from a negedge), advance the model, land on the next negedge.
  task automatic tick(input logic [3:0] r, input logic [39:0] a);
    logic [3:0] elig;
    int start, w;
    req = r; req_addr = a;
    elig = r & ~m_gnt;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    w = -1;
    for (int k = 0; k < 4; k++) begin
      if (w < 0 && elig[(start + k) % 4]) w = (start + k) % 4;
    end
    if (w >= 0) begin
      m_gnt = 4'b0001 << w; m_en = 1'b1; m_addr = a[w*10 +: 10]; m_ptr = (w + 1) % 4;
    end else begin
      m_gnt = '0; m_en = 1'b0;
    end
    for (int j = 3; j > 0; j--) begin hv[j] = hv[j-1]; hid[j] = hid[j-1]; ha[j] = ha[j-1]; end
    hv[0] = m_en; hid[0] = (w >= 0) ? w : 0; ha[0] = m_addr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0; req_addr = '0; reset = 1'b0;
    model_clear();
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (gnt1 !== 4'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt1); end
    total++; if (en1 !== 1'b0) begin bad++; $display("FAIL reset_rom_en got=%b exp=0", en1); end
    total++; if (addr1 !== 10'h0) begin bad++; $display("FAIL reset_rom_addr got=%h exp=000", addr1); end
    total++; if (v3 !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", v3); end
    total++; if (id3 !== 2'd0) begin bad++; $display("FAIL reset_rd_id got=%0d exp=0", id3); end
  endtask

  task automatic test_single();
    do_reset();
    tick(4'b0001, {30'h0, 10'h155});
    total++; if (gnt1 !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b exp=0001", gnt1); end
    total++; if (en1 !== 1'b1) begin bad++; $display("FAIL single_rom_en got=%b exp=1", en1); end
    total++; if (addr1 !== 10'h155) begin bad++; $display("FAIL single_rom_addr got=%h exp=155", addr1); end
    tick(4'b0001, {30'h0, 10'h155});
    total++; if (gnt1 !== 4'b0000) begin bad++; $display("FAIL single_no_regrant got=%b exp=0000", gnt1); end
    total++; if (addr1 !== 10'h155) begin bad++; $display("FAIL single_addr_hold got=%h exp=155", addr1); end
    total++; if (v1 !== 1'b1) begin bad++; $display("FAIL single_rd_valid got=%b exp=1", v1); end
    total++; if (id1 !== 2'(REQ_PLAYER)) begin bad++; $display("FAIL single_rd_id got=%0d exp=0", id1); end
    total++; if (rd1 !== romf(10'h155)) begin bad++; $display("FAIL single_rd_data got=%h exp=%h", rd1, romf(10'h155)); end
    tick(4'b0000, '0);
    total++; if (v1 !== 1'b0 || v2 !== 1'b1) begin bad++; $display("FAIL single_lat2 got=%b%b exp=01", v1, v2); end
    tick(4'b0000, '0);
    total++; if (v3 !== 1'b1 || rd3 !== romf(10'h155)) begin bad++; $display("FAIL single_lat3 got=%b/%h exp=1/%h", v3, rd3, romf(10'h155)); end
  endtask

  task automatic test_all_requesting();
    logic [39:0] a;
    a = {10'h103, 10'h102, 10'h101, 10'h100};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(4'b1111, a);
      total++; if (gnt1 !== (4'b0001 << (i % 4))) begin bad++; $display("FAIL all_gnt[%0d] got=%b exp=%b", i, gnt1, 4'b0001 << (i % 4)); end
      total++; if (en1 !== 1'b1) begin bad++; $display("FAIL all_rom_en[%0d] got=%b exp=1", i, en1); end
      total++; if (addr1 !== 10'(10'h100 + i % 4)) begin bad++; $display("FAIL all_addr[%0d] got=%h exp=%h", i, addr1, 10'(10'h100 + i % 4)); end
    end
  endtask

  task automatic test_rr_pointer();
    logic [3:0] exp_g;
    do_reset();
    tick(4'b0010, {20'h0, 10'h0AA, 10'h0});
    total++; if (gnt1 !== 4'b0010) begin bad++; $display("FAIL rr_setup got=%b exp=0010", gnt1); end
    tick(4'b0000, '0);
    tick(4'b0011, {20'h0, 10'h011, 10'h010});
    total++; if (gnt1 !== 4'b0001) begin bad++; $display("FAIL rr_wrap got=%b exp=0001", gnt1); end
    tick(4'b0000, '0);
    tick(4'b0011, {20'h0, 10'h011, 10'h010});
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    exp_g = 4'b0001;
`else
    exp_g = 4'b0010;
`endif
    total++; if (gnt1 !== exp_g) begin bad++; $display("FAIL rr_next got=%b exp=%b", gnt1, exp_g); end
  endtask

  task automatic test_reset_inflight();
    logic [39:0] a;
    a = {10'h3C3, 10'h2B2, 10'h1A1, 10'h090};
    do_reset();
    for (int i = 0; i < 3; i++) tick(4'b0011, a);
    total++; if (en3 !== 1'b1) begin bad++; $display("FAIL inflight_en got=%b exp=1", en3); end
    reset = 1'b0;
    #1;
    total++; if (gnt1 !== 4'b0 || en1 !== 1'b0 || addr1 !== 10'h0) begin bad++; $display("FAIL inflight_clr1 got=%b/%b/%h exp=0000/0/000", gnt1, en1, addr1); end
    total++; if (v1 !== 1'b0 || id1 !== 2'd0) begin bad++; $display("FAIL inflight_clr_rd1 got=%b/%0d exp=0/0", v1, id1); end
    total++; if (v3 !== 1'b0 || en3 !== 1'b0 || addr3 !== 10'h0) begin bad++; $display("FAIL inflight_clr3 got=%b/%b/%h exp=0/0/000", v3, en3, addr3); end
    req = '0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(4'b0000, '0);
      total++; if ({v1, v2, v3} !== 3'b000) begin bad++; $display("FAIL inflight_drop[%0d] got=%b exp=000", i, {v1, v2, v3}); end
    end
    tick(4'b1001, a);
    total++; if (gnt1 !== 4'b0001) begin bad++; $display("FAIL inflight_first got=%b exp=0001", gnt1); end
  endtask

  task automatic test_rom_lat_sweep();
    int n_g, n1, n2, n3;
    n_g = 0; n1 = 0; n2 = 0; n3 = 0;
    do_reset();
    for (int c = 0; c < 304; c++) begin
      if (c < 300) tick(4'($urandom_range(0, 15)), 40'({$urandom(), $urandom()}));
      else tick(4'b0000, '0);
      n_g += int'(m_en); n1 += int'(v1); n2 += int'(v2); n3 += int'(v3);
      total++; if (gnt1 !== m_gnt || gnt3 !== m_gnt) begin bad++; $display("FAIL sweep_gnt[%0d] got=%b/%b exp=%b", c, gnt1, gnt3, m_gnt); end
      total++; if (en2 !== m_en || addr2 !== m_addr) begin bad++; $display("FAIL sweep_rom[%0d] got=%b/%h exp=%b/%h", c, en2, addr2, m_en, m_addr); end
      total++; if (v1 !== hv[1] || v2 !== hv[2] || v3 !== hv[3]) begin bad++; $display("FAIL sweep_valid[%0d] got=%b%b%b exp=%b%b%b", c, v1, v2, v3, hv[1], hv[2], hv[3]); end
      if (hv[1]) begin
        total++; if (id1 !== 2'(hid[1]) || rd1 !== romf(ha[1])) begin bad++; $display("FAIL sweep_rd1[%0d] got=%0d/%h exp=%0d/%h", c, id1, rd1, hid[1], romf(ha[1])); end
      end
      if (hv[2]) begin
        total++; if (id2 !== 2'(hid[2]) || rd2 !== romf(ha[2])) begin bad++; $display("FAIL sweep_rd2[%0d] got=%0d/%h exp=%0d/%h", c, id2, rd2, hid[2], romf(ha[2])); end
      end
      if (hv[3]) begin
        total++; if (id3 !== 2'(hid[3]) || rd3 !== romf(ha[3])) begin bad++; $display("FAIL sweep_rd3[%0d] got=%0d/%h exp=%0d/%h", c, id3, rd3, hid[3], romf(ha[3])); end
      end
    end
    total++; if (n1 != n_g || n2 != n_g || n3 != n_g) begin bad++; $display("FAIL sweep_count got=%0d/%0d/%0d exp=%0d", n1, n2, n3, n_g); end
  endtask

  initial begin
    reset = 1'b0; req = '0; req_addr = '0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_single();
    test_all_requesting();
    test_rr_pointer();
    test_reset_inflight();
    test_rom_lat_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
